// File: rtl/uart_status_fifo.sv
// UART receive FIFO with sticky error flags, TX-buffer occupancy and a maskable registered interrupt.
// Sits between the UART RX/TX datapaths and the CPU register interface.
module uart_status_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned THRESH = DEPTH / 2
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         rxMvDatEn,
    input  logic [DATA_W-1:0]            rxDat,
    input  logic                         setPErr,
    input  logic                         setFErr,
    input  logic                         rxBRegCe,
    input  logic                         txBRegCe,
    input  logic                         txMvDatEn,
    input  logic                         sRegCe,
    input  logic                         ieWe,
    input  logic [3:0]                   ieDat,
    output logic [DATA_W-1:0]            rxDatOut,
    output logic [$clog2(DEPTH+1)-1:0]   rxCount,
    output logic [7:0]                   stat,
    output logic [3:0]                   ie,
    output logic                         irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             o_err, o_err_nx;
    logic             p_err, p_err_nx;
    logic             f_err, f_err_nx;
    logic             tx_empty, tx_empty_nx;
    logic [3:0]       ie_nx;
    logic             irq_nx;

    logic rx_full, rx_empty, rx_thresh, do_push, do_pop;

    // Occupancy-derived status and accepted push/pop qualification
    always_comb begin
        rx_full   = (count == CNT_W'(DEPTH));
        rx_empty  = (count == '0);
        rx_thresh = (count >= CNT_W'(THRESH));
        do_pop    = rxBRegCe && !rx_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the word
        do_push   = rxMvDatEn && (!rx_full || do_pop);
    end

    // Next-state logic
    always_comb begin
        wr_ptr_nx   = wr_ptr;
        rd_ptr_nx   = rd_ptr;
        count_nx    = count;
        o_err_nx    = o_err && !sRegCe;
        p_err_nx    = p_err && !sRegCe;
        f_err_nx    = f_err && !sRegCe;
        tx_empty_nx = tx_empty;
        ie_nx       = ie;
        irq_nx      = 1'b0;

        if (do_push) begin
            wr_ptr_nx = wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_nx = rd_ptr + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_nx = count + CNT_W'(1);
            2'b01:   count_nx = count - CNT_W'(1);
            default: count_nx = count;
        endcase

        // Setting a sticky flag takes priority over a same-cycle status read
        if (rxMvDatEn && !do_push) o_err_nx = 1'b1;
        if (do_push && setPErr)    p_err_nx = 1'b1;
        if (do_push && setFErr)    f_err_nx = 1'b1;

        if (txBRegCe) begin
            tx_empty_nx = 1'b0;
        end else if (txMvDatEn) begin
            tx_empty_nx = 1'b1;
        end

        if (ieWe) begin
            ie_nx = ieDat;
        end

        irq_nx = |(ie & {tx_empty, (o_err | p_err | f_err), rx_thresh, !rx_empty});
    end

    // State registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            o_err    <= 1'b0;
            p_err    <= 1'b0;
            f_err    <= 1'b0;
            tx_empty <= 1'b1;
            ie       <= '0;
            irq      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            count    <= count_nx;
            o_err    <= o_err_nx;
            p_err    <= p_err_nx;
            f_err    <= f_err_nx;
            tx_empty <= tx_empty_nx;
            ie       <= ie_nx;
            irq      <= irq_nx;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rxDat;
        end
    end

    assign rxDatOut = mem[rd_ptr];
    assign rxCount  = count;
    assign stat     = {1'b0, rx_full, tx_empty, rx_thresh, f_err, p_err, o_err, !rx_empty};

endmodule
